regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the five-stage pipeline and its dual-issue variant. Provides NUM_RD combinational read ports, NUM_WR synchronous write ports with optional same-cycle write-to-read bypass, and tracks which registers have an in-flight producer so decode can detect RAW/WAW hazards and stall.

## Interface
- REG_WIDTH, 64, data width of each register
- REG_COUNT, 32, number of architectural registers (power of two, ≥2); AW = $clog2(REG_COUNT)
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  packed write addresses, port p at [p*AW +: AW]
- wr_data  in  NUM_WR*REG_WIDTH  packed write data
- rd_addr  in  NUM_RD*AW  packed read addresses
- rd_data  out  NUM_RD*REG_WIDTH  packed read data
- rd_busy  out  NUM_RD  read register has a pending producer
- issue_en  in  1  decode claims issue_rd as destination this cycle
- issue_rd  in  AW  destination being claimed
- issue_ready  out  1  issue_rd not busy; claim allowed
- flush  in  1  discard all pending claims
- busy_vec  out  REG_COUNT  registered scoreboard state

## Operation
- Storage: REG_COUNT x REG_WIDTH array plus REG_COUNT busy bits.
- Write: on posedge clk, each port p with wr_en[p] writes wr_data[p] to wr_addr[p]. Same address on two ports: higher port index wins. Address 0 dropped when ZERO_REG=1.
- Any committed write to register r clears busy[r].
- Claim: issue_en && issue_ready sets busy[issue_rd] on posedge clk. Ignored if issue_rd = 0 and ZERO_REG=1. issue_en while issue_ready=0: no state change (decode must hold).
- Same-cycle claim and write to the same register: claim wins, busy stays 1 (new producer supersedes old).
- flush: clears all busy bits; takes priority over claims that cycle. Writes in the flush cycle still update the array.
- issue_ready = ~busy[issue_rd], except 1 for register 0 when ZERO_REG=1. Combinational from registered state only; no same-cycle write-clear lookahead.
- Read (combinational): rd_data[i] = array[rd_addr[i]]; 0 for address 0 when ZERO_REG=1.
  - BYPASS=1 and a write port targets rd_addr[i] this cycle: return that port's wr_data (highest port on conflict), and rd_busy[i] = 0.
  - Otherwise rd_busy[i] = busy[rd_addr[i]].
- Reset (any time, including mid-claim or mid-write): array cleared to 0, busy_vec = 0; clock-edge writes and claims in the reset window are lost.

## Timing
- Reset values: busy_vec 0, issue_ready 1, rd_busy 0, rd_data 0 for every address.
- Write latency: visible to reads the next cycle; same cycle when BYPASS=1.
- Claim latency: busy bit, rd_busy and issue_ready reflect a claim from the cycle after the edge.
- Write clear: busy drop is visible on rd_busy the same cycle (BYPASS=1) or the next cycle (BYPASS=0). It is visible on issue_ready the next cycle in both modes.
- No internal pipeline stages; all outputs settle within one cycle of input change.

## Test plan
- Reset then read all 32 addresses on both ports -> rd_data 0, rd_busy 0, busy_vec 0, issue_ready 1.
- Write 0xDEAD_BEEF to x5 with rd_addr0=5 in the same cycle -> BYPASS=1: rd_data0=0xDEAD_BEEF immediately. BYPASS=0: old value that cycle, new value next cycle.
- Write 0x1234 to x0 with ZERO_REG=1, then read x0 -> 0. Claim x0 -> busy_vec unchanged, issue_ready stays 1.
- Claim x7, next cycle set issue_rd=7 -> issue_ready 0, rd_busy 1 on x7. Then write x7=0x55 -> busy clears, issue_ready 1 the following cycle.
- NUM_WR=2: both ports write x9 (0xA, 0xB) in the same cycle as a claim of x9 -> x9=0xB, busy_vec[9]=1. Then assert flush -> busy_vec 0.
- Claim x3 and x4, then assert rst asynchronously mid-cycle -> busy_vec and x3/x4 contents 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bundle of the write, read, issue and scoreboard signals between the pipeline and regfile_sb.
// The pipeline side uses the master modport; the register file uses the slave modport.
interface regfile_sb_if #(
    parameter int REG_WIDTH = 64,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1
);
    localparam int AW = $clog2(REG_COUNT);

    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR*AW-1:0]        wr_addr;
    logic [NUM_WR*REG_WIDTH-1:0] wr_data;
    logic [NUM_RD*AW-1:0]        rd_addr;
    logic [NUM_RD*REG_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic                        issue_en;
    logic [AW-1:0]               issue_rd;
    logic                        issue_ready;
    logic                        flush;
    logic [REG_COUNT-1:0]        busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        input  rd_data, rd_busy, issue_ready, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        output rd_data, rd_busy, issue_ready, busy_vec
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Decode claims destinations through issue_*, writeback clears them, flush drops every claim.
module regfile_sb #(
    parameter int REG_WIDTH = 64,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(REG_COUNT);
    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [REG_WIDTH-1:0]        mem_q [REG_COUNT];
    logic [REG_WIDTH-1:0]        mem_d [REG_COUNT];
    logic [REG_COUNT-1:0]        busy_q;
    logic [REG_COUNT-1:0]        busy_d;
    logic [REG_COUNT-1:0]        wr_hit;
    logic                        claim_ok;
    logic                        issue_ready_c;
    logic [NUM_RD*REG_WIDTH-1:0] rd_data_c;
    logic [NUM_RD-1:0]           rd_busy_c;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    // Deliberately looks only at registered state: a write landing this cycle
    // does not free the destination for a new claim until the next cycle.
    always_comb begin
        issue_ready_c = is_zero(bus.issue_rd) || !busy_q[bus.issue_rd];
    end

    always_comb begin : write_next
        logic [AW-1:0] wa;
        // NOTE: every variable gets a default before any conditional update,
        // otherwise the unassigned paths would infer latches.
        mem_d  = mem_q;
        wr_hit = '0;
        wa     = '0;
        // Ascending port order lets the highest-index port win on an address clash.
        for (int p = 0; p < NUM_WR; p++) begin
            wa = bus.wr_addr[p*AW +: AW];
            if (bus.wr_en[p] && !is_zero(wa)) begin
                mem_d[wa]  = bus.wr_data[p*REG_WIDTH +: REG_WIDTH];
                wr_hit[wa] = 1'b1;
            end
        end
    end

    always_comb begin : busy_next
        claim_ok = bus.issue_en && issue_ready_c && !is_zero(bus.issue_rd);
        busy_d   = busy_q & ~wr_hit;
        // A claim applied after the write-clear means a new producer supersedes the old one.
        if (bus.flush) begin
            busy_d = '0;
        end else if (claim_ok) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
    end

    // NOTE: combinational blocks above use blocking '=' so later statements see
    // earlier results; state below is updated with non-blocking '<=' only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            // NOTE: the array is reset on purpose because architectural state must
            // read zero after reset; this keeps it out of plain RAM macros.
            for (int r = 0; r < REG_COUNT; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            mem_q  <= mem_d;
        end
    end

    always_comb begin : read_ports
        logic [AW-1:0]        ra;
        logic [REG_WIDTH-1:0] rdat;
        logic                 rbusy;
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        rdat      = '0;
        rbusy     = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra    = bus.rd_addr[i*AW +: AW];
            rdat  = mem_q[ra];
            rbusy = busy_q[ra];
            if (BP) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == ra)) begin
                        rdat  = bus.wr_data[p*REG_WIDTH +: REG_WIDTH];
                        rbusy = 1'b0;
                    end
                end
            end
            if (is_zero(ra)) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
            rd_data_c[i*REG_WIDTH +: REG_WIDTH] = rdat;
            rd_busy_c[i]                        = rbusy;
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_busy     = rd_busy_c;
    assign bus.issue_ready = issue_ready_c;
    assign bus.busy_vec    = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a dual-write bypassing instance driven from a vector
// table, plus a non-bypassing single-write instance and asynchronous-reset sequences.
module tb_regfile_sb;
    localparam int W  = 64;
    localparam int N  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_applied    = 0;
    int   n_miscompares = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.REG_WIDTH(W), .REG_COUNT(N), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    regfile_sb_if #(.REG_WIDTH(W), .REG_COUNT(N), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    regfile_sb #(
        .REG_WIDTH(W), .REG_COUNT(N), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    regfile_sb #(
        .REG_WIDTH(W), .REG_COUNT(N), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
    ) u_dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    typedef struct {
        logic [1:0]    wr_en;
        logic [AW-1:0] wa0, wa1;
        logic [W-1:0]  wd0, wd1;
        logic [AW-1:0] ra0, ra1;
        logic          ien;
        logic [AW-1:0] ird;
        logic          flush;
        logic [W-1:0]  e_rd0, e_rd1;
        logic          e_busy0, e_busy1, e_ready;
        logic [N-1:0]  e_bv;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                           input logic [W-1:0] wd0, input logic [W-1:0] wd1,
                           input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                           input logic ien, input logic [AW-1:0] ird, input logic fl);
        bus_a.wr_en    = we;
        bus_a.wr_addr  = {wa1, wa0};
        bus_a.wr_data  = {wd1, wd0};
        bus_a.rd_addr  = {ra1, ra0};
        bus_a.issue_en = ien;
        bus_a.issue_rd = ird;
        bus_a.flush    = fl;
    endtask

    task automatic drive_b(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                           input logic [AW-1:0] ra0, input logic ien, input logic [AW-1:0] ird);
        bus_b.wr_en    = we;
        bus_b.wr_addr  = wa;
        bus_b.wr_data  = wd;
        bus_b.rd_addr  = {5'd0, ra0};
        bus_b.issue_en = ien;
        bus_b.issue_rd = ird;
        bus_b.flush    = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                                input logic [W-1:0] wd0, input logic [W-1:0] wd1,
                                input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                input logic ien, input logic [AW-1:0] ird, input logic fl,
                                input logic [W-1:0] e_rd0, input logic [W-1:0] e_rd1,
                                input logic e_b0, input logic e_b1, input logic e_rdy,
                                input logic [N-1:0] e_bv);
        vec_t v;
        v.wr_en = we;  v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.ra0 = ra0;   v.ra1 = ra1; v.ien = ien; v.ird = ird; v.flush = fl;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy0 = e_b0; v.e_busy1 = e_b1;
        v.e_ready = e_rdy; v.e_bv = e_bv;
        return v;
    endfunction

    initial begin
        // Each row: inputs held for one cycle, expected combinational outputs in that
        // cycle, and busy_vec as registered before that cycle's clock edge.
        //          we     wa0    wa1    wd0            wd1    ra0    ra1    ien   ird    fl     rd0            rd1            b0    b1    rdy   busy_vec
        vecs[0]  = mk(2'b01, 5'd5,  5'd0,  64'hDEAD_BEEF, 64'h0, 5'd5,  5'd5,  1'b0, 5'd0,  1'b0,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0);
        vecs[1]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd5,  5'd0,  1'b0, 5'd0,  1'b0,  64'hDEAD_BEEF, 64'h0,         1'b0, 1'b0, 1'b1, 32'h0);
        vecs[2]  = mk(2'b01, 5'd0,  5'd0,  64'h1234,      64'h0, 5'd0,  5'd5,  1'b0, 5'd0,  1'b0,  64'h0,         64'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd0,  5'd5,  1'b1, 5'd0,  1'b0,  64'h0,         64'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0);
        vecs[4]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd0,  5'd0,  1'b1, 5'd7,  1'b0,  64'h0,         64'h0,         1'b0, 1'b0, 1'b1, 32'h0);
        vecs[5]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd7,  5'd0,  1'b0, 5'd7,  1'b0,  64'h0,         64'h0,         1'b1, 1'b0, 1'b0, 32'h80);
        vecs[6]  = mk(2'b01, 5'd7,  5'd0,  64'h55,        64'h0, 5'd7,  5'd7,  1'b0, 5'd7,  1'b0,  64'h55,        64'h55,        1'b0, 1'b0, 1'b0, 32'h80);
        vecs[7]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd7,  5'd5,  1'b0, 5'd7,  1'b0,  64'h55,        64'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0);
        vecs[8]  = mk(2'b11, 5'd9,  5'd9,  64'hA,         64'hB, 5'd9,  5'd9,  1'b1, 5'd9,  1'b0,  64'hB,         64'hB,         1'b0, 1'b0, 1'b1, 32'h0);
        vecs[9]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd9,  5'd7,  1'b1, 5'd9,  1'b0,  64'hB,         64'h55,        1'b1, 1'b0, 1'b0, 32'h200);
        vecs[10] = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd9,  5'd3,  1'b1, 5'd3,  1'b1,  64'hB,         64'h0,         1'b1, 1'b0, 1'b1, 32'h200);
        vecs[11] = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd9,  5'd3,  1'b0, 5'd3,  1'b0,  64'hB,         64'h0,         1'b0, 1'b0, 1'b1, 32'h0);
        vecs[12] = mk(2'b11, 5'd13, 5'd12, 64'h66,        64'h77, 5'd12, 5'd13, 1'b1, 5'd12, 1'b0,  64'h77,        64'h66,        1'b0, 1'b0, 1'b1, 32'h0);
        vecs[13] = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd12, 5'd13, 1'b0, 5'd12, 1'b0,  64'h77,        64'h66,        1'b1, 1'b0, 1'b0, 32'h1000);
        vecs[14] = mk(2'b01, 5'd12, 5'd0,  64'h88,        64'h0, 5'd12, 5'd0,  1'b0, 5'd12, 1'b1,  64'h88,        64'h0,         1'b0, 1'b0, 1'b0, 32'h1000);
        vecs[15] = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0, 5'd12, 5'd0,  1'b0, 5'd12, 1'b0,  64'h88,        64'h0,         1'b0, 1'b0, 1'b1, 32'h0);

        drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive_b(1'b0, 5'd0, 64'h0, 5'd0, 1'b0, 5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state across every address on both read ports.
        for (int a = 0; a < N; a++) begin
            @(negedge clk);
            drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, AW'(a), AW'(N - 1 - a), 1'b0, AW'(a), 1'b0);
            #1;
            check($sformatf("reset rd0 x%0d", a), bus_a.rd_data[63:0], 64'h0);
            check($sformatf("reset rd1 x%0d", N - 1 - a), bus_a.rd_data[127:64], 64'h0);
            check($sformatf("reset busy0 x%0d", a), 64'(bus_a.rd_busy[0]), 64'h0);
            check($sformatf("reset busy1 x%0d", N - 1 - a), 64'(bus_a.rd_busy[1]), 64'h0);
            check($sformatf("reset ready x%0d", a), 64'(bus_a.issue_ready), 64'h1);
            check($sformatf("reset busy_vec @%0d", a), 64'(bus_a.busy_vec), 64'h0);
        end

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive_a(vecs[i].wr_en, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
                    vecs[i].ra0, vecs[i].ra1, vecs[i].ien, vecs[i].ird, vecs[i].flush);
            #1;
            check($sformatf("v%0d rd0", i), bus_a.rd_data[63:0], vecs[i].e_rd0);
            check($sformatf("v%0d rd1", i), bus_a.rd_data[127:64], vecs[i].e_rd1);
            check($sformatf("v%0d busy0", i), 64'(bus_a.rd_busy[0]), 64'(vecs[i].e_busy0));
            check($sformatf("v%0d busy1", i), 64'(bus_a.rd_busy[1]), 64'(vecs[i].e_busy1));
            check($sformatf("v%0d ready", i), 64'(bus_a.issue_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d busy_vec", i), 64'(bus_a.busy_vec), 64'(vecs[i].e_bv));
        end
        @(negedge clk);
        drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Non-bypassing instance: write and busy-clear appear one cycle later.
        drive_b(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 1'b0, 5'd0);
        #1 check("nb write same cycle", bus_b.rd_data[63:0], 64'h0);
        @(negedge clk);
        drive_b(1'b0, 5'd0, 64'h0, 5'd5, 1'b0, 5'd0);
        #1 check("nb write next cycle", bus_b.rd_data[63:0], 64'hDEAD_BEEF);
        @(negedge clk);
        drive_b(1'b0, 5'd0, 64'h0, 5'd7, 1'b1, 5'd7);
        #1 check("nb claim ready", 64'(bus_b.issue_ready), 64'h1);
        @(negedge clk);
        drive_b(1'b0, 5'd0, 64'h0, 5'd7, 1'b0, 5'd7);
        #1;
        check("nb claimed busy", 64'(bus_b.rd_busy[0]), 64'h1);
        check("nb claimed ready", 64'(bus_b.issue_ready), 64'h0);
        @(negedge clk);
        drive_b(1'b1, 5'd7, 64'h55, 5'd7, 1'b0, 5'd7);
        #1;
        check("nb clear busy same", 64'(bus_b.rd_busy[0]), 64'h1);
        check("nb clear data same", bus_b.rd_data[63:0], 64'h0);
        check("nb clear ready same", 64'(bus_b.issue_ready), 64'h0);
        @(negedge clk);
        drive_b(1'b0, 5'd0, 64'h0, 5'd7, 1'b0, 5'd7);
        #1;
        check("nb clear busy next", 64'(bus_b.rd_busy[0]), 64'h0);
        check("nb clear data next", bus_b.rd_data[63:0], 64'h55);
        check("nb clear ready next", 64'(bus_b.issue_ready), 64'h1);

        // Asynchronous reset mid-cycle with claims and data outstanding.
        @(negedge clk);
        drive_a(2'b11, 5'd3, 5'd4, 64'h33, 64'h44, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
        drive_b(1'b0, 5'd0, 64'h0, 5'd5, 1'b0, 5'd0);
        @(negedge clk);
        drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        @(negedge clk);
        drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
        #1;
        check("pre-rst rd x3", bus_a.rd_data[63:0], 64'h33);
        check("pre-rst rd x4", bus_a.rd_data[127:64], 64'h44);
        check("pre-rst busy_vec", 64'(bus_a.busy_vec), 64'h18);
        #1 rst = 1'b1;
        #1;
        check("async rst busy_vec", 64'(bus_a.busy_vec), 64'h0);
        check("async rst rd x3", bus_a.rd_data[63:0], 64'h0);
        check("async rst rd x4", bus_a.rd_data[127:64], 64'h0);
        check("async rst busy x3", 64'(bus_a.rd_busy[0]), 64'h0);
        check("async rst nb x5", bus_b.rd_data[63:0], 64'h0);

        // Write and claim presented across an edge while reset is held are lost.
        drive_a(2'b01, 5'd5, 5'd0, 64'h5A, 64'h0, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 5'd5, 5'd6, 1'b0, 5'd6, 1'b0);
        #1;
        check("rst window write lost", bus_a.rd_data[63:0], 64'h0);
        check("rst window claim lost", 64'(bus_a.busy_vec), 64'h0);
        check("rst window ready", 64'(bus_a.issue_ready), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end
endmodule
